// File: rtl/parser_pkg.sv
// -----------------------------------------------------------------------------
// parser_pkg
// Shared definitions for the parser-side head field extractor.
//   - Default geometry of the tagged head-slice stream (data/tag widths, tag
//     bit positions, offset unit size, extracted field width and count).
//   - extract_state_e : packet-tracking states of the extractor.
//   - ext_offset_t    : one per-field offset descriptor {enable, offset}.
// -----------------------------------------------------------------------------
package parser_pkg;

    // Tagged head slice: data in [HEAD_WIDTH-1:0], tag bits above it.
    localparam int HEAD_WIDTH      = 512;
    localparam int TAG_WIDTH       = 8;
    localparam int TAG_START_BIT   = 0;
    localparam int TAG_VALID_BIT   = 1;
    localparam int TAG_TAIL_BIT    = 2;

    // Offsets count SHIFT_WIDTH-bit units from the MSB of slice 0.
    localparam int SHIFT_WIDTH     = 16;
    localparam int KEY_FIELD_WIDTH = 32;
    localparam int KEY_FIELD_NUM   = 8;
    localparam int MAX_SLICES      = 4;
    localparam int OFFSET_WIDTH    = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } extract_state_e;

    // Packed so a field's slot in the offset bus maps onto it directly:
    // enable in the MSB, offset units below.
    typedef struct packed {
        logic                    en;
        logic [OFFSET_WIDTH-1:0] off;
    } ext_offset_t;

endpackage

// File: rtl/field_window_mux.sv
// -----------------------------------------------------------------------------
// field_window_mux
// Combinational selector of one KEY_FIELD_WIDTH field out of the two-slice
// extraction window {preSlice, curSlice}. Unit u selects the field whose MSB
// sits u*SHIFT_WIDTH bits below the MSB of the upper (previous) slice, so a
// field may run from the previous slice into the current one.
// Ports:
//   i_window  2*HEAD_WIDTH    {previous slice, current slice}
//   i_unit    UNIT_WIDTH      unit index within a slice
//   o_field   KEY_FIELD_WIDTH selected field
// -----------------------------------------------------------------------------
module field_window_mux #(
    parameter int HEAD_WIDTH      = 512,
    parameter int SHIFT_WIDTH     = 16,
    parameter int KEY_FIELD_WIDTH = 32,
    parameter int UNIT_WIDTH      = 5
) (
    input  logic [2*HEAD_WIDTH-1:0]    i_window,
    input  logic [UNIT_WIDTH-1:0]      i_unit,
    output logic [KEY_FIELD_WIDTH-1:0] o_field
);

    localparam int UNITS = HEAD_WIDTH / SHIFT_WIDTH;

    // Every unit start is a constant bit position, so the select is a plain
    // UNITS-way mux rather than a wide barrel shifter.
    logic [KEY_FIELD_WIDTH-1:0] candidate [UNITS];

    for (genvar u = 0; u < UNITS; u++) begin : g_cand
        assign candidate[u] = i_window[2*HEAD_WIDTH - u*SHIFT_WIDTH - 1 -: KEY_FIELD_WIDTH];
    end

    assign o_field = candidate[i_unit];

endmodule

// File: rtl/head_field_extract.sv
// -----------------------------------------------------------------------------
// head_field_extract
// Watches the tagged head-slice stream, captures up to KEY_FIELD_NUM key
// fields at offsets latched with the start slice, and publishes them as the
// ext-field vector. The head itself passes through unmodified, two cycles
// late.
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_head       tagged head slice, data in [HEAD_WIDTH-1:0]
//   i_extOffset  per field {enable, offset units}, sampled on the start slice
//   o_head       i_head delayed by two cycles
//   o_extField   extracted fields, field 0 in the lowest bits
//   o_extValid   per-field captured flag
//   o_extDone    one-cycle pulse once the fields are final
// -----------------------------------------------------------------------------
module head_field_extract #(
    parameter int HEAD_WIDTH      = parser_pkg::HEAD_WIDTH,
    parameter int TAG_WIDTH       = parser_pkg::TAG_WIDTH,
    parameter int TAG_START_BIT   = parser_pkg::TAG_START_BIT,
    parameter int TAG_VALID_BIT   = parser_pkg::TAG_VALID_BIT,
    parameter int TAG_TAIL_BIT    = parser_pkg::TAG_TAIL_BIT,
    parameter int SHIFT_WIDTH     = parser_pkg::SHIFT_WIDTH,
    parameter int KEY_FIELD_WIDTH = parser_pkg::KEY_FIELD_WIDTH,
    parameter int KEY_FIELD_NUM   = parser_pkg::KEY_FIELD_NUM,
    parameter int MAX_SLICES      = parser_pkg::MAX_SLICES,
    parameter int OFFSET_WIDTH    = parser_pkg::OFFSET_WIDTH
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]           i_head,
    input  logic [KEY_FIELD_NUM*(OFFSET_WIDTH+1)-1:0] i_extOffset,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0]           o_head,
    output logic [KEY_FIELD_NUM*KEY_FIELD_WIDTH-1:0]  o_extField,
    output logic [KEY_FIELD_NUM-1:0]                  o_extValid,
    output logic                                      o_extDone
);

    import parser_pkg::*;

    localparam int UNITS       = HEAD_WIDTH / SHIFT_WIDTH;
    localparam int UNIT_WIDTH  = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int IDX_WIDTH   = $clog2(MAX_SLICES + 1);
    localparam int FRAME_WIDTH = HEAD_WIDTH + TAG_WIDTH;

    // -------------------------------------------------------------------------
    // Slice decode
    // -------------------------------------------------------------------------
    logic                  slice_valid;
    logic                  slice_start;
    logic                  slice_tail;
    logic [HEAD_WIDTH-1:0] head_data;

    assign head_data   = i_head[HEAD_WIDTH-1:0];
    assign slice_valid = i_head[HEAD_WIDTH + TAG_VALID_BIT];
    // Start and tail only count on accepted slices; bubbles are transparent.
    assign slice_start = slice_valid & i_head[HEAD_WIDTH + TAG_START_BIT];
    assign slice_tail  = slice_valid & i_head[HEAD_WIDTH + TAG_TAIL_BIT];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    extract_state_e state_q, state_d;

    logic [FRAME_WIDTH-1:0]                             head_p1_q, head_p1_d;
    logic [FRAME_WIDTH-1:0]                             head_p2_q, head_p2_d;
    logic [HEAD_WIDTH-1:0]                              pre_slice_q, pre_slice_d;
    logic [IDX_WIDTH-1:0]                               slice_idx_q, slice_idx_d;
    logic [KEY_FIELD_NUM-1:0][OFFSET_WIDTH:0]           ext_off_q, ext_off_d;
    logic [KEY_FIELD_NUM-1:0]                           ext_valid_q, ext_valid_d;
    logic [KEY_FIELD_NUM-1:0][KEY_FIELD_WIDTH-1:0]      ext_field_q, ext_field_d;

    // -------------------------------------------------------------------------
    // Extraction window and per-field selectors
    // -------------------------------------------------------------------------
    // The upper half is the previously accepted slice (whose index is
    // slice_idx_q); the lower half is the slice arriving now, or zeros while
    // flushing the tail so fields running past the end read as zero.
    logic [HEAD_WIDTH-1:0]      window_lo;
    logic [2*HEAD_WIDTH-1:0]    window;
    logic [UNIT_WIDTH-1:0]      field_unit [KEY_FIELD_NUM];
    logic [KEY_FIELD_WIDTH-1:0] mux_field  [KEY_FIELD_NUM];
    logic [KEY_FIELD_NUM-1:0]   field_hit;
    logic                       capture_en;

    assign window_lo = (state_q == FLUSH) ? {HEAD_WIDTH{1'b0}} : head_data;
    assign window    = {pre_slice_q, window_lo};

    for (genvar f = 0; f < KEY_FIELD_NUM; f++) begin : g_field
        assign field_unit[f] = UNIT_WIDTH'(int'(ext_off_q[f][OFFSET_WIDTH-1:0]) % UNITS);

        field_window_mux #(
            .HEAD_WIDTH      (HEAD_WIDTH),
            .SHIFT_WIDTH     (SHIFT_WIDTH),
            .KEY_FIELD_WIDTH (KEY_FIELD_WIDTH),
            .UNIT_WIDTH      (UNIT_WIDTH)
        ) u_mux (
            .i_window (window),
            .i_unit   (field_unit[f]),
            .o_field  (mux_field[f])
        );
    end

    // A field is taken one accepted slice after its home slice, i.e. when the
    // home slice sits in the upper half of the window. A saturated index marks
    // slices past MAX_SLICES, which never match.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path can leave it unassigned and infer a latch.
        field_hit = '0;
        for (int f = 0; f < KEY_FIELD_NUM; f++) begin
            field_hit[f] = ext_off_q[f][OFFSET_WIDTH]
                         && (int'(slice_idx_q) < MAX_SLICES)
                         && (int'(ext_off_q[f][OFFSET_WIDTH-1:0]) / UNITS == int'(slice_idx_q));
        end
    end

    assign capture_en = ((state_q == ACTIVE) && slice_valid) || (state_q == FLUSH);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // A start slice restarts extraction from any state, which aborts an
    // unfinished packet and also covers a start arriving during DONE.
    always_comb begin
        state_d = state_q;
        if (slice_start) begin
            state_d = slice_tail ? FLUSH : ACTIVE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                ACTIVE:  state_d = slice_tail ? FLUSH : ACTIVE;
                FLUSH:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_extDone = 1'b0;
        if (state_q == DONE) begin
            o_extDone = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        head_p1_d   = i_head;
        head_p2_d   = head_p1_q;
        pre_slice_d = pre_slice_q;
        slice_idx_d = slice_idx_q;
        ext_off_d   = ext_off_q;
        ext_valid_d = ext_valid_q;
        ext_field_d = ext_field_q;

        if (slice_start) begin
            ext_off_d   = i_extOffset;
            pre_slice_d = head_data;
            slice_idx_d = '0;
            ext_valid_d = '0;
            ext_field_d = '0;
        end else if (capture_en) begin
            for (int f = 0; f < KEY_FIELD_NUM; f++) begin
                if (field_hit[f]) begin
                    ext_valid_d[f] = 1'b1;
                    ext_field_d[f] = mux_field[f];
                end
            end
            // Only a real slice advances the window; FLUSH reuses the tail.
            if (state_q == ACTIVE) begin
                pre_slice_d = head_data;
                if (int'(slice_idx_q) < MAX_SLICES) begin
                    slice_idx_d = slice_idx_q + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_p1_q   <= '0;
            head_p2_q   <= '0;
            slice_idx_q <= '0;
            ext_off_q   <= '0;
            ext_valid_q <= '0;
            ext_field_q <= '0;
        end else begin
            head_p1_q   <= head_p1_d;
            head_p2_q   <= head_p2_d;
            slice_idx_q <= slice_idx_d;
            ext_off_q   <= ext_off_d;
            ext_valid_q <= ext_valid_d;
            ext_field_q <= ext_field_d;
        end
    end

    // NOTE: the previous-slice register is left out of reset on purpose: it
    // is only read in ACTIVE/FLUSH, which are entered solely through a start
    // slice that loads it first, so resetting it would buy nothing.
    always_ff @(posedge i_clk) begin
        pre_slice_q <= pre_slice_d;
    end

    assign o_head     = head_p2_q;
    assign o_extField = ext_field_q;
    assign o_extValid = ext_valid_q;

endmodule
